berzerk_input_ctrl: RTL

Player-input conditioning stage feeding the Berzerk core's control and coin inputs. It decodes HPS PS/2 key events into held-button state and merges them with the two MiSTer joysticks. It applies the rotate mapping and produces registered player, start and coin signals. Coins are generated as timed pulses with a bounded queue, so that fast key taps or auto-coin from start are never lost to the core's coin sampling.

---
 rtl/berzerk_input_pkg.sv | 77 +++++++
 rtl/berzerk_input_ctrl_if.sv | 26 ++
 rtl/berzerk_coin_pulser.sv | 83 ++++++++
 rtl/berzerk_input_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/berzerk_input_pkg.sv
// Shared constants for the Berzerk input stage: PS/2 scan codes, pad bit
// positions, held-key slots and the coin pulser state encoding.
package berzerk_input_pkg;

  localparam logic [7:0] SC_UP1    = 8'h75;
  localparam logic [7:0] SC_DOWN1  = 8'h72;
  localparam logic [7:0] SC_LEFT1  = 8'h6B;
  localparam logic [7:0] SC_RIGHT1 = 8'h74;
  localparam logic [7:0] SC_FIRE1A = 8'h29;
  localparam logic [7:0] SC_FIRE1B = 8'h14;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_F2     = 8'h06;
  localparam logic [7:0] SC_KEY1   = 8'h16;
  localparam logic [7:0] SC_KEY2   = 8'h1E;
  localparam logic [7:0] SC_COIN5  = 8'h2E;
  localparam logic [7:0] SC_COIN6  = 8'h36;
  localparam logic [7:0] SC_UP2    = 8'h2D;
  localparam logic [7:0] SC_DOWN2  = 8'h2B;
  localparam logic [7:0] SC_LEFT2  = 8'h23;
  localparam logic [7:0] SC_RIGHT2 = 8'h34;
  localparam logic [7:0] SC_FIRE2  = 8'h1C;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_FIRE   = 4;
  localparam int JB_START1 = 5;
  localparam int JB_START2 = 6;

  localparam int NUM_PLAYERS = 2;

  // One held-state slot per physical key, so two keys sharing a function
  // each produce their own press/release edges.
  localparam int K_UP1 = 0, K_DOWN1 = 1, K_LEFT1 = 2, K_RIGHT1 = 3;
  localparam int K_FIRE1A = 4, K_FIRE1B = 5;
  localparam int K_F1 = 6, K_F2 = 7, K_KEY1 = 8, K_KEY2 = 9;
  localparam int K_COIN5 = 10, K_COIN6 = 11;
  localparam int K_UP2 = 12, K_DOWN2 = 13, K_LEFT2 = 14, K_RIGHT2 = 15, K_FIRE2 = 16;
  localparam int NUM_KEYS = 17;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} coin_state_e;

  function automatic key_vec_t key_onehot(input logic [7:0] code);
    key_vec_t oh;
    oh = '0;
    case (code)
      SC_UP1:    oh[K_UP1]    = 1'b1;
      SC_DOWN1:  oh[K_DOWN1]  = 1'b1;
      SC_LEFT1:  oh[K_LEFT1]  = 1'b1;
      SC_RIGHT1: oh[K_RIGHT1] = 1'b1;
      SC_FIRE1A: oh[K_FIRE1A] = 1'b1;
      SC_FIRE1B: oh[K_FIRE1B] = 1'b1;
      SC_F1:     oh[K_F1]     = 1'b1;
      SC_F2:     oh[K_F2]     = 1'b1;
      SC_KEY1:   oh[K_KEY1]   = 1'b1;
      SC_KEY2:   oh[K_KEY2]   = 1'b1;
      SC_COIN5:  oh[K_COIN5]  = 1'b1;
      SC_COIN6:  oh[K_COIN6]  = 1'b1;
      SC_UP2:    oh[K_UP2]    = 1'b1;
      SC_DOWN2:  oh[K_DOWN2]  = 1'b1;
      SC_LEFT2:  oh[K_LEFT2]  = 1'b1;
      SC_RIGHT2: oh[K_RIGHT2] = 1'b1;
      SC_FIRE2:  oh[K_FIRE2]  = 1'b1;
      default:   ;
    endcase
    return oh;
  endfunction

  // Direction vectors use the pad layout: [3] up, [2] down, [1] left, [0] right.
  function automatic logic [3:0] rot_dir(input logic [3:0] raw, input logic rot);
    return rot ? {raw[JB_LEFT], raw[JB_RIGHT], raw[JB_DOWN], raw[JB_UP]} : raw;
  endfunction

endpackage

// File: rtl/berzerk_input_ctrl_if.sv
// Host-side inputs (PS/2, pads, rotate) and conditioned core-side controls.
interface berzerk_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic        up1, down1, left1, right1, fire1;
  logic        up2, down2, left2, right2, fire2;
  logic        start1, start2;
  logic        coin1;
  logic [1:0]  coin_pending;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate,
    input  up1, down1, left1, right1, fire1,
    input  up2, down2, left2, right2, fire2,
    input  start1, start2, coin1, coin_pending
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate,
    output up1, down1, left1, right1, fire1,
    output up2, down2, left2, right2, fire2,
    output start1, start2, coin1, coin_pending
  );
endinterface

// File: rtl/berzerk_coin_pulser.sv
// Coin request queue plus pulse/gap timer: each queued request becomes one
// fixed-width coin pulse followed by an enforced low gap.
module berzerk_coin_pulser
  import berzerk_input_pkg::*;
#(
  parameter int COIN_TICKS = 4000000,
  parameter int GAP_TICKS  = 4000000,
  parameter int QUEUE_MAX  = 3
)(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       req,
  output logic       coin,
  output logic [1:0] pending
);

  localparam int MAX_T = (COIN_TICKS > GAP_TICKS) ? COIN_TICKS : GAP_TICKS;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam int QW    = $clog2(QUEUE_MAX + 1);

  localparam logic [CW-1:0] COIN_LD = CW'(COIN_TICKS);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_TICKS);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [QW-1:0] QMAX    = QW'(QUEUE_MAX);

  coin_state_e   state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [QW-1:0] q_q, q_n;
  logic          deq;

  // Leaving on cnt<=1 keeps coin high for exactly COIN_TICKS cycles counting
  // the entry cycle; the gap then adds one IDLE cycle before the next dequeue.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    deq     = 1'b0;
    case (state_q)
      IDLE: if (q_q != '0) begin
        deq     = 1'b1;
        cnt_n   = COIN_LD;
        state_n = PULSE;
      end
      PULSE: begin
        cnt_n = cnt_q - ONE;
        if (cnt_q <= ONE) begin
          cnt_n   = GAP_LD;
          state_n = GAP;
        end
      end
      GAP: begin
        cnt_n = cnt_q - ONE;
        if (cnt_q <= ONE) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    q_n = q_q;
    case ({req, deq})
      2'b10:   q_n = (q_q == QMAX) ? q_q : q_q + QW'(1);
      2'b01:   q_n = q_q - QW'(1);
      default: q_n = q_q;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      coin    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      q_q     <= q_n;
      coin    <= (state_n == PULSE);
    end
  end

  assign pending = 2'(q_q);

endmodule

// File: rtl/berzerk_input_ctrl.sv
// Berzerk input conditioning: PS/2 key decode, pad merge, rotate mapping,
// start/coin edge detection and the coin pulse generator.
module berzerk_input_ctrl
  import berzerk_input_pkg::*;
#(
  parameter int CLK_HZ    = 40000000,
  parameter int COIN_MS   = 100,
  parameter int GAP_MS    = 100,
  parameter int QUEUE_MAX = 3
)(
  input logic                clk_sys,
  input logic                reset_n,
  berzerk_input_ctrl_if.slave io
);

  localparam int COIN_TICKS = CLK_HZ / 1000 * COIN_MS;
  localparam int GAP_TICKS  = CLK_HZ / 1000 * GAP_MS;

  logic                         tog_q, armed_q;
  key_vec_t                     key_q, key_hit;
  logic                         key_evt;
  logic [NUM_PLAYERS-1:0][15:0] pad;
  logic [NUM_PLAYERS-1:0][3:0]  key_dir, dir_q;
  logic [NUM_PLAYERS-1:0]       key_fire, fire_q;
  logic [1:0]                   start_w, start_q, start_d;
  logic [1:0]                   coin_keys, coin_d;
  logic                         coin_req;

  // armed_q holds off the first post-reset edge so a stale toggle level
  // only seeds the copy instead of replaying an old key event.
  assign key_hit = key_onehot(io.ps2_key[7:0]);
  assign key_evt = armed_q && (io.ps2_key[10] != tog_q);

  assign pad      = {io.joystick_1, io.joystick_0};
  assign key_dir  = {{key_q[K_UP2], key_q[K_DOWN2], key_q[K_LEFT2], key_q[K_RIGHT2]},
                     {key_q[K_UP1], key_q[K_DOWN1], key_q[K_LEFT1], key_q[K_RIGHT1]}};
  assign key_fire = {key_q[K_FIRE2], key_q[K_FIRE1A] | key_q[K_FIRE1B]};

  assign start_w[0] = key_q[K_F1] | key_q[K_KEY1] | pad[0][JB_START1] | pad[1][JB_START1];
  assign start_w[1] = key_q[K_F2] | key_q[K_KEY2] | pad[0][JB_START2] | pad[1][JB_START2];
  assign coin_keys  = {key_q[K_COIN6], key_q[K_COIN5]};

  assign coin_req = |(start_q & ~start_d) | |(coin_keys & ~coin_d);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q   <= 1'b0;
      armed_q <= 1'b0;
      key_q   <= '0;
      dir_q   <= '0;
      fire_q  <= '0;
      start_q <= '0;
      start_d <= '0;
      coin_d  <= '0;
    end else begin
      tog_q   <= io.ps2_key[10];
      armed_q <= 1'b1;
      if (key_evt) key_q <= (key_q & ~key_hit) | (key_hit & {NUM_KEYS{io.ps2_key[9]}});
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        dir_q[p]  <= rot_dir(key_dir[p] | pad[p][3:0], io.rotate);
        fire_q[p] <= key_fire[p] | pad[p][JB_FIRE];
      end
      start_q <= start_w;
      start_d <= start_q;
      coin_d  <= coin_keys;
    end
  end

  assign io.up1    = dir_q[0][JB_UP];
  assign io.down1  = dir_q[0][JB_DOWN];
  assign io.left1  = dir_q[0][JB_LEFT];
  assign io.right1 = dir_q[0][JB_RIGHT];
  assign io.fire1  = fire_q[0];
  assign io.up2    = dir_q[1][JB_UP];
  assign io.down2  = dir_q[1][JB_DOWN];
  assign io.left2  = dir_q[1][JB_LEFT];
  assign io.right2 = dir_q[1][JB_RIGHT];
  assign io.fire2  = fire_q[1];
  assign io.start1 = start_q[0];
  assign io.start2 = start_q[1];

  berzerk_coin_pulser #(
    .COIN_TICKS (COIN_TICKS),
    .GAP_TICKS  (GAP_TICKS),
    .QUEUE_MAX  (QUEUE_MAX)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (coin_req),
    .coin    (io.coin1),
    .pending (io.coin_pending)
  );

  logic unused_bits;
  assign unused_bits = ^{io.joystick_0[15:7], io.joystick_1[15:7], io.ps2_key[8]};

endmodule
